// File: rtl/alu_defs_pkg.sv
// Shared op-code and FSM state encodings for the bit-serial ALU and its 1-bit slice.
package alu_defs;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/alu_1bit_serial.sv
// One ALU bit-slice: AND/OR/full-add with b inverted for SUB/SLT (op[2]).
module alu_1bit_serial
  import alu_defs::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       c_in,
  input  logic [2:0] op,
  output logic       r,
  output logic       c_out,
  output logic       set
);

  logic b_eff;
  logic sum;

  assign b_eff = b ^ op[2];
  assign sum   = a ^ b_eff ^ c_in;
  assign c_out = (a & b_eff) | (a & c_in) | (b_eff & c_in);
  assign set   = sum;

  // SLT places its result from the controller, so the slice itself emits 0.
  always_comb begin
    r = 1'b0;
    case (op)
      OP_AND:         r = a & b;
      OP_OR:          r = a | b;
      OP_ADD, OP_SUB: r = sum;
      default:        r = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: one bit per clock through a single slice, LSB first.
// Result and flags update only on the edge entering DONE; done pulses for one cycle.
module alu_serial_ctrl
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             c_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] sh;

  logic             bit_r;
  logic             bit_cout;
  logic             bit_set;

  logic [WIDTH-1:0] res_full;
  logic             slt_set;
  logic [WIDTH-1:0] nxt_r;
  logic             nxt_zero;
  logic             nxt_c;
  logic             nxt_ov;

  alu_1bit_serial u_slice (
    .a     (a_q[idx]),
    .b     (b_q[idx]),
    .c_in  (carry),
    .op    (op_q),
    .r     (bit_r),
    .c_out (bit_cout),
    .set   (bit_set)
  );

  // On the last edge the MSB has not yet landed in sh, so splice it in from the slice.
  always_comb begin
    res_full            = sh;
    res_full[WIDTH-1]   = bit_r;
  end

  assign slt_set = bit_set ^ (carry ^ bit_cout);

  always_comb begin
    nxt_r  = '0;
    nxt_c  = 1'b0;
    nxt_ov = 1'b0;
    case (op_q)
      OP_AND, OP_OR: nxt_r = res_full;
      OP_ADD, OP_SUB: begin
        nxt_r  = res_full;
        nxt_c  = bit_cout;
        nxt_ov = carry ^ bit_cout;
      end
      OP_SLT:  nxt_r = {{(WIDTH-1){1'b0}}, slt_set};
      default: nxt_r = '0;
    endcase
  end

  assign nxt_zero = (nxt_r == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      sh       <= '0;
      r        <= '0;
      zero     <= 1'b0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            idx   <= '0;
            carry <= op[2];
            sh    <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sh[idx] <= bit_r;
          carry   <= bit_cout;
          if (idx == LAST) begin
            idx      <= '0;
            r        <= nxt_r;
            zero     <= nxt_zero;
            c_out    <= nxt_c;
            overflow <= nxt_ov;
            state    <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule
